// File: rtl/md_stall_ctrl_pkg.sv
// rtl/md_stall_ctrl_pkg.sv - shared multiply/divide latency constants and state encodings
package md_stall_ctrl_pkg;

    localparam int MD_MULT_LAT = 5;
    localparam int MD_DIV_LAT  = 10;
    localparam int MD_CNT_W    = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_countdown.sv
// rtl/md_countdown.sv - loadable down counter that stops at zero and pulses on reaching it
module md_countdown
    import md_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_pulse_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             zero_pulse_q, zero_pulse_d;

    // Next count: load wins, otherwise step down and hold at zero.
    always_comb begin
        count_d      = count_q;
        zero_pulse_d = (count_q == CNT_W'(1));
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count and pulse registers; reset drops the count without a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            zero_pulse_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            zero_pulse_q <= zero_pulse_d;
        end
    end

    assign count_o      = count_q;
    assign zero_pulse_o = zero_pulse_q;

endmodule

// File: rtl/md_stall_ctrl.sv
// rtl/md_stall_ctrl.sv - HI/LO stall and mult/div latency tracker (optional counters: MD_STALL_PERF_EN)
module md_stall_ctrl
    import md_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT,
    parameter int DIV_LAT  = MD_DIV_LAT,
    parameter int CNT_W    = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_hilo_use,
    input  logic             e_md_start,
    input  logic             e_md_is_div,
    output logic             stall_d,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
`ifdef MD_STALL_PERF_EN
    output logic [31:0]      stall_cycles,
    output logic [15:0]      md_ops,
`endif
    output logic             md_done
);

    if (MULT_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
        $error("md_stall_ctrl: MULT_LAT and DIV_LAT must be at least 1");
    end
    if (MULT_LAT >= (1 << CNT_W) || DIV_LAT >= (1 << CNT_W)) begin : g_bad_width
        $error("md_stall_ctrl: CNT_W too narrow for the configured latencies");
    end

    md_state_e        state_q, state_d;
    logic             load;
    logic [CNT_W-1:0] load_val;

    // Next state: accept a start only when idle; leave RUN as the count hits its last cycle.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (e_md_start) begin
                    load    = 1'b1;
                    state_d = MD_RUN;
                end
            end
            MD_RUN: begin
                if (remaining == CNT_W'(1)) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign load_val = e_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    md_countdown #(
        .CNT_W (CNT_W)
    ) u_countdown (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .load_val_i   (load_val),
        .count_o      (remaining),
        .zero_pulse_o (md_done)
    );

    // A start in E is already an in-flight op for the instruction behind it.
    assign busy    = (remaining != '0);
    assign stall_d = d_hilo_use & (e_md_start | busy);

`ifdef MD_STALL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] md_ops_q;

    // Saturating stall-cycle count and wrapping accepted-op count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            md_ops_q       <= '0;
        end else begin
            if (stall_d && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (load) begin
                md_ops_q <= md_ops_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign md_ops       = md_ops_q;
`endif

endmodule

// File: tb/tb_md_stall_ctrl.sv
// tb/tb_md_stall_ctrl.sv - directed and random checks of md_stall_ctrl against a latency model
module tb_md_stall_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             d_hilo_use;
    logic             e_md_start;
    logic             e_md_is_div;
    logic             stall_d;
    logic             busy;
    logic [CNT_W-1:0] remaining;
    logic             md_done;
`ifdef MD_STALL_PERF_EN
    logic [31:0]      stall_cycles;
    logic [15:0]      md_ops;
`endif

    md_stall_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .d_hilo_use   (d_hilo_use),
        .e_md_start   (e_md_start),
        .e_md_is_div  (e_md_is_div),
        .stall_d      (stall_d),
        .busy         (busy),
        .remaining    (remaining),
`ifdef MD_STALL_PERF_EN
        .stall_cycles (stall_cycles),
        .md_ops       (md_ops),
`endif
        .md_done      (md_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles left on the in-flight op, and whether it finished last edge.
    int          m_rem;
    bit          m_done;
    int unsigned m_stall;
    logic [15:0] m_ops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_stall();
        return d_hilo_use && (e_md_start || (m_rem > 0));
    endfunction

    task automatic model_reset();
        m_rem   = 0;
        m_done  = 0;
        m_stall = 0;
        m_ops   = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".remaining"}, 32'(remaining), 32'(m_rem));
        chk({tag, ".busy"},      32'(busy),      32'(m_rem > 0));
        chk({tag, ".md_done"},   32'(md_done),   32'(m_done));
        chk({tag, ".stall_d"},   32'(stall_d),   32'(exp_stall()));
`ifdef MD_STALL_PERF_EN
        chk({tag, ".stall_cycles"}, stall_cycles, m_stall);
        chk({tag, ".md_ops"},       32'(md_ops),  32'(m_ops));
`endif
    endtask

    // Check the current cycle, then advance one edge and update the model.
    task automatic tick(input string tag);
        bit st;
        #1;
        check_all(tag);
        st = exp_stall();
        @(posedge clk);
        if (st && m_stall != 32'hFFFF_FFFF) m_stall++;
        m_done = (m_rem == 1);
        if (m_rem == 0 && e_md_start) begin
            m_rem = e_md_is_div ? DIV_LAT : MULT_LAT;
            m_ops = m_ops + 16'd1;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
        end
        #3;
    endtask

    int n_stall;
    int n_done;

    initial begin
        reset       = 1'b1;
        d_hilo_use  = 1'b0;
        e_md_start  = 1'b0;
        e_md_is_div = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;

        // Reset then idle: a HI/LO user must not stall.
        d_hilo_use = 1'b1;
        #1;
        chk("reset.stall_d", 32'(stall_d), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.remaining", 32'(remaining), 32'd0);
        tick("reset_idle");

        // mult followed by mflo.
        e_md_start  = 1'b1;
        e_md_is_div = 1'b0;
        #1;
        chk("mult_issue.stall_d", 32'(stall_d), 32'd1);
        tick("mult_issue");
        e_md_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("mult_seq.remaining", 32'(remaining), 32'(5 - i));
            chk("mult_seq.md_done", 32'(md_done), 32'(i == 5));
            chk("mult_seq.stall_d", 32'(stall_d), 32'(i < 5));
            tick("mult_seq");
        end
`ifdef MD_STALL_PERF_EN
        chk("perf.stall_cycles", stall_cycles, 32'd6);
        chk("perf.md_ops", 32'(md_ops), 32'd1);
`endif

        // div followed by mfhi.
        e_md_start  = 1'b1;
        e_md_is_div = 1'b1;
        #1;
        n_stall = int'(stall_d);
        tick("div_issue");
        e_md_start = 1'b0;
        chk("div_load.remaining", 32'(remaining), 32'd10);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_stall += int'(stall_d);
            n_done  += int'(md_done);
            if (i == 10) chk("div_done_cycle.md_done", 32'(md_done), 32'd1);
            tick("div_seq");
        end
        chk("div.stall_total", 32'(n_stall), 32'd11);
        chk("div.done_count", 32'(n_done), 32'd1);

        // Unrelated D-stage instruction while an op runs.
        d_hilo_use  = 1'b0;
        e_md_start  = 1'b1;
        e_md_is_div = 1'b1;
        tick("unrel_issue");
        e_md_start = 1'b0;
        repeat (3) tick("unrel_run");
        #1;
        chk("unrel.remaining", 32'(remaining), 32'd7);
        chk("unrel.stall_d", 32'(stall_d), 32'd0);
        tick("unrel_run");
        chk("unrel.next", 32'(remaining), 32'd6);

        // Back-to-back start in the completion cycle.
        d_hilo_use = 1'b1;
        for (int i = 0; i < 20 && !m_done; i++) tick("b2b_wait");
        chk("b2b.at_done", 32'(md_done), 32'd1);
        e_md_start  = 1'b1;
        e_md_is_div = 1'b0;
        tick("b2b_issue");
        e_md_start = 1'b0;
        chk("b2b.reload", 32'(remaining), 32'd5);
        chk("b2b.single_pulse", 32'(md_done), 32'd0);
        tick("b2b_run");
        tick("b2b_run");
        chk("spurious.at3", 32'(remaining), 32'd3);
        e_md_start  = 1'b1;
        e_md_is_div = 1'b1;
        tick("spurious_start");
        e_md_start = 1'b0;
        chk("spurious.ignored", 32'(remaining), 32'd2);
        repeat (4) tick("b2b_drain");

        // Asynchronous reset in the middle of a run.
        e_md_start  = 1'b1;
        e_md_is_div = 1'b1;
        tick("areset_issue");
        e_md_start = 1'b0;
        repeat (4) tick("areset_run");
        chk("areset.before", 32'(remaining), 32'd6);
        #1;
        reset = 1'b1;
        #1;
        chk("areset.remaining", 32'(remaining), 32'd0);
        chk("areset.busy", 32'(busy), 32'd0);
        chk("areset.md_done", 32'(md_done), 32'd0);
        model_reset();
        reset = 1'b0;
        repeat (8) tick("areset_after");

        // Random traffic, including starts while running.
        for (int i = 0; i < 400; i++) begin
            e_md_start  = ($urandom_range(0, 3) == 0);
            e_md_is_div = 1'($urandom_range(0, 1));
            d_hilo_use  = 1'($urandom_range(0, 1));
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_stall_ctrl.md
Name: md_stall_ctrl

Overview:
- Issue/stall side of the HI/LO multiply-divide interface. It tracks the in-flight mult/multu/div/divu latency with its own countdown.
- It generates the D-stage stall for every instruction that touches HI/LO, and a one-cycle completion pulse.
- Sits between the D-stage decoder and the E-stage ALU/MDU; it is the consumer of the busy/latency contract the MDU implements.

Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu issues
- DIV_LAT, 10, busy cycles after a div/divu issues
- CNT_W, 4, counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- d_hilo_use  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- e_md_start  input  1  E-stage holds a valid mult/multu/div/divu this cycle (MDU samples it at the next edge)
- e_md_is_div  input  1  qualifies e_md_start: 1 = div/divu, 0 = mult/multu
- stall_d  output  1  freeze PC/F/D, insert bubble into E
- busy  output  1  countdown non-zero
- remaining  output  CNT_W  current countdown value
- md_done  output  1  one-cycle pulse when the countdown reaches 0

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: state=IDLE, remaining=0, busy=0, md_done=0, stall_d=0 (combinational, since d_hilo_use is gated by an all-zero state).
- States:
  - IDLE: remaining==0.
  - RUN: remaining>0.
- Transitions:
  - IDLE, e_md_start=1: load remaining with (e_md_is_div ? DIV_LAT : MULT_LAT) at the edge, go to RUN.
  - RUN, remaining>1: decrement by 1 per cycle.
  - RUN, remaining==1: next edge sets remaining=0, IDLE, md_done=1 for exactly that cycle.
- Latency: start sampled at edge T → busy high for cycles T+1..T+LAT → md_done high in cycle T+LAT+1 with busy=0.
- stall_d (combinational): d_hilo_use & (e_md_start | busy).
  - The E-stage start counts as busy in its own cycle, so a back-to-back HI/LO user stalls immediately.
- e_md_start while RUN cannot occur architecturally, since stall_d blocks it. If it does occur: ignore it, keep counting, keep state; no reload.
- e_md_start during the md_done cycle (remaining==0): legal; reload normally. md_done still pulses that cycle.
- mthi/mtlo/mfhi/mflo never reach E as a start. They only stall while busy; no counter effect.
- Reset mid-RUN: counter cleared immediately (async); no md_done pulse is produced.
- MULT_LAT or DIV_LAT of 0: illegal; the implementation may elaborate-time error.
- Arithmetic: the counter is unsigned CNT_W bits and never wraps below 0.

Optional Feature:
- Macro: MD_STALL_PERF_EN.
- Defined:
  - Adds output stall_cycles [31:0]: counts every cycle with stall_d=1.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
  - Adds output md_ops [15:0]: counts accepted starts (IDLE & e_md_start), wrapping modulo 2^16.
- Undefined: neither port exists; no counters are synthesized; all other behaviour identical.

Decomposition:
- Shared constants header (alongside the existing ALU opcode constants):
  - MULT_LAT/DIV_LAT defaults
  - state encodings MD_IDLE=1'b0, MD_RUN=1'b1
- The HI/LO-use decode stays in the decoder, not here.
- One natural sub-module: md_countdown (loadable, saturating-at-0 down counter with zero-crossing pulse). The FSM and stall logic stay in the top.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release, d_hilo_use=1 → stall_d=0, busy=0, remaining=0.
- mult then mflo: e_md_start=1, e_md_is_div=0 at edge T; d_hilo_use=1 held → stall_d=1 in cycle T and T+1..T+5; md_done=1 and stall_d=0 in T+6; remaining sequence 5,4,3,2,1,0.
- div then mfhi: e_md_is_div=1 → remaining loads 10; stall_d high for 11 cycles total; md_done once at T+11.
- Unrelated D instruction during RUN: d_hilo_use=0 while remaining=7 → stall_d=0; countdown continues undisturbed.
- Back-to-back at completion: new mult start in the md_done cycle → remaining reloads 5 next edge, md_done pulses exactly once; spurious start at remaining=3 is ignored (next value 2).
- Async reset mid-RUN: assert reset at remaining=6 between edges → remaining=0, busy=0 immediately, no md_done. With MD_STALL_PERF_EN: the scenario 2 sequence yields stall_cycles=6, md_ops=1.
